// File: rtl/subleq_mc_core.sv
// Multi-cycle SUBLEQ core: unified memory, program load port, start/halt control,
// valid/ready memory-mapped I/O at IO_ADDR and self-loop halt detection.
module subleq_mc_core #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int IO_ADDR = 2**AW-1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FA       = 4'd1;
  localparam logic [3:0] S_FB       = 4'd2;
  localparam logic [3:0] S_FC       = 4'd3;
  localparam logic [3:0] S_OA       = 4'd4;
  localparam logic [3:0] S_IN_WAIT  = 4'd5;
  localparam logic [3:0] S_OB       = 4'd6;
  localparam logic [3:0] S_EX       = 4'd7;
  localparam logic [3:0] S_OUT_WAIT = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;

  localparam logic [AW-1:0] IO_A = IO_ADDR[AW-1:0];

  logic [3:0]    state;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [AW-1:0] rc;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] mem [0:2**AW-1];

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] diff;
  logic          taken;
  logic          ctl_idle;

  assign ctl_idle = (state == S_IDLE) || (state == S_HALT);
  assign busy     = !ctl_idle;
  assign halted   = (state == S_HALT);
  assign in_ready = (state == S_IN_WAIT);

  assign diff  = opb - opa;
  assign taken = diff[DW-1] || (diff == '0);

  // One read port shared by all fetch/operand states; data lands in the target register.
  always_comb begin
    rd_addr = pc;
    case (state)
      S_FB:    rd_addr = pc + AW'(1);
      S_FC:    rd_addr = pc + AW'(2);
      S_OA:    rd_addr = ra;
      S_OB:    rd_addr = rb;
      default: rd_addr = pc;
    endcase
  end

  // Memory is deliberately not reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (ctl_idle && ld_en)
      mem[ld_addr] <= ld_data;
    else if (state == S_EX && rst_n)
      mem[rb] <= diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      opa       <= '0;
      opb       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= '0;
            state <= S_FA;
          end
        end
        S_FA: begin
          ra    <= mem[rd_addr][AW-1:0];
          state <= S_FB;
        end
        S_FB: begin
          rb    <= mem[rd_addr][AW-1:0];
          state <= S_FC;
        end
        S_FC: begin
          rc    <= mem[rd_addr][AW-1:0];
          state <= S_OA;
        end
        S_OA: begin
          if (ra == IO_A) begin
            state <= S_IN_WAIT;
          end else begin
            opa   <= mem[rd_addr];
            state <= S_OB;
          end
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            opa   <= in_data;
            state <= S_OB;
          end
        end
        S_OB: begin
          if (rb == IO_A) begin
            out_data  <= opa;
            out_valid <= 1'b1;
            state     <= S_OUT_WAIT;
          end else begin
            opb   <= mem[rd_addr];
            state <= S_EX;
          end
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc + AW'(3);
            state     <= S_FA;
          end
        end
        S_EX: begin
          // A taken branch onto itself can never make progress: treat it as halt.
          if (taken && rc == pc) begin
            state <= S_HALT;
          end else if (taken) begin
            pc    <= rc;
            state <= S_FA;
          end else begin
            pc    <= pc + AW'(3);
            state <= S_FA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_mc_core.sv
// Self-checking bench for subleq_mc_core: small SUBLEQ programs with expected
// memory results and output words queued at load time, compared as the core delivers them.
module tb_subleq_mc_core;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       halted;
  logic [7:0] pc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } mem_exp_t;

  mem_exp_t   mem_q[$];
  logic [7:0] out_q[$];

  subleq_mc_core #(.AW(8), .DW(8), .IO_ADDR(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .halted(halted), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (halted) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_in_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_mem_q(input string tag);
    mem_exp_t e;
    while (mem_q.size() > 0) begin
      e = mem_q.pop_front();
      checks++;
      if (dut.mem[e.addr] !== e.data) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h expected %h", tag, e.addr, dut.mem[e.addr], e.data);
      end else
        $display("ok   %s mem[%0d]=%h", tag, e.addr, e.data);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || pc !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b halted=%b in_ready=%b out_valid=%b out_data=%h pc=%0d expected all zero", busy, halted, in_ready, out_valid, out_data, pc);
    end else
      $display("ok   reset outputs idle");
  endtask

  task automatic test_basic;
    int n;
    load(0, 6); load(1, 7); load(2, 3);
    load(3, 8); load(4, 8); load(5, 3);
    load(6, 5); load(7, 7); load(8, 0);
    mem_q.push_back('{8'd7, 8'd2});
    mem_q.push_back('{8'd6, 8'd5});
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic busy after start: got %b expected 1", busy);
    end else
      $display("ok   basic busy after start");
    wait_halt(50, n);
    checks++;
    if (n !== 12 || pc !== 8'd3) begin
      errors++;
      $display("FAIL basic halt: edge=%0d pc=%0d expected edge=12 pc=3", n, pc);
    end else
      $display("ok   basic halted on edge 12 pc=3");
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL basic after halt: busy=%b halted=%b expected 0/1", busy, halted);
    end else
      $display("ok   basic stays halted");
    drain_mem_q("basic");
  endtask

  task automatic test_taken;
    int n;
    load(0, 6); load(1, 7); load(2, 9);
    load(6, 7); load(7, 7); load(8, 0);
    load(9, 8); load(10, 8); load(11, 9);
    mem_q.push_back('{8'd7, 8'd0});
    pulse_start();
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++;
    if (pc !== 8'd9 || halted !== 1'b0) begin
      errors++;
      $display("FAIL taken jump: pc=%0d halted=%b expected pc=9 halted=0", pc, halted);
    end else
      $display("ok   taken jump pc 0->9");
    wait_halt(50, n);
    checks++;
    if (n < 0 || pc !== 8'd9) begin
      errors++;
      $display("FAIL taken halt: edge=%0d pc=%0d expected halt at pc=9", n, pc);
    end else
      $display("ok   taken halted pc=9");
    drain_mem_q("taken");
  endtask

  task automatic test_signed_wrap;
    int n;
    load(0, 6); load(1, 7); load(2, 12);
    load(3, 8); load(4, 8); load(5, 3);
    load(6, 1); load(7, 8'h80); load(8, 0);
    mem_q.push_back('{8'd7, 8'h7F});
    pulse_start();
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++;
    if (pc !== 8'd3) begin
      errors++;
      $display("FAIL signed not-taken: pc=%0d expected 3", pc);
    end else
      $display("ok   signed wrap not taken pc=3");
    drain_mem_q("signed");
    wait_halt(50, n);
    checks++;
    if (n < 0 || pc !== 8'd3) begin
      errors++;
      $display("FAIL signed halt: edge=%0d pc=%0d expected halt at pc=3", n, pc);
    end else
      $display("ok   signed halted pc=3");
  endtask

  task automatic test_input;
    int n;
    bit ok;
    load(0, 255); load(1, 7); load(2, 3);
    load(3, 8); load(4, 8); load(5, 3);
    load(7, 10); load(8, 0);
    mem_q.push_back('{8'd7, 8'd6});
    in_valid = 1'b0;
    pulse_start();
    wait_in_ready(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL input wait: in_ready=%b expected 1 within 20 cycles", in_ready);
    end else
      $display("ok   input in_ready raised");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL input stall cycle %0d: in_ready=%b expected 1", i, in_ready);
      end else
        $display("ok   input stall cycle %0d in_ready=1", i);
    end
    in_data = 8'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL input accept: in_ready=%b expected 0", in_ready);
    end else
      $display("ok   input accepted");
    wait_halt(50, n);
    checks++;
    if (n < 0 || pc !== 8'd3) begin
      errors++;
      $display("FAIL input halt: edge=%0d pc=%0d expected halt at pc=3", n, pc);
    end else
      $display("ok   input halted pc=3");
    drain_mem_q("input");
  endtask

  task automatic test_output;
    int n;
    bit ok;
    logic [7:0] exp_out;
    load(0, 6); load(1, 255); load(2, 3);
    load(3, 8); load(4, 8); load(5, 3);
    load(6, 8'h2A); load(8, 0); load(255, 8'h11);
    out_q.push_back(8'h2A);
    mem_q.push_back('{8'd6, 8'h2A});
    mem_q.push_back('{8'd255, 8'h11});
    out_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL output wait: out_valid=%b expected 1 within 20 cycles", out_valid);
    end else
      $display("ok   output out_valid raised");
    exp_out = out_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_out) begin
        errors++;
        $display("FAIL output hold cycle %0d: valid=%b data=%h expected 1/%h", i, out_valid, out_data, exp_out);
      end else
        $display("ok   output hold cycle %0d data=%h", i, out_data);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pc !== 8'd3) begin
      errors++;
      $display("FAIL output handshake: valid=%b pc=%0d expected 0/3", out_valid, pc);
    end else
      $display("ok   output handshake pc=3");
    wait_halt(50, n);
    checks++;
    if (n < 0 || pc !== 8'd3) begin
      errors++;
      $display("FAIL output halt: edge=%0d pc=%0d expected halt at pc=3", n, pc);
    end else
      $display("ok   output halted pc=3");
    drain_mem_q("output");
  endtask

  task automatic test_reset_ctrl;
    int n;
    bit ok;
    load(0, 255); load(1, 7); load(2, 3);
    load(3, 8); load(4, 8); load(5, 3);
    load(7, 10); load(8, 0);
    in_valid = 1'b0;
    pulse_start();
    wait_in_ready(20, ok);
    rst_n = 1'b0;
    #2;
    checks++;
    if (!ok || busy !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b0 || pc !== 8'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async reset: reached=%b busy=%b halted=%b in_ready=%b pc=%0d out_valid=%b expected 1/0/0/0/0/0", ok, busy, halted, in_ready, pc, out_valid);
    end else
      $display("ok   async reset returned to idle");
    mem_q.push_back('{8'd0, 8'd255});
    mem_q.push_back('{8'd7, 8'd10});
    drain_mem_q("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle after reset: busy=%b expected 0", busy);
    end else
      $display("ok   idle after reset release");
    pulse_start();
    wait_in_ready(20, ok);
    ld_en = 1'b1; ld_addr = 8'd7; ld_data = 8'd99; start = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0; start = 1'b0;
    checks++;
    if (!ok || in_ready !== 1'b1 || dut.mem[7] !== 8'd10) begin
      errors++;
      $display("FAIL busy ignore: reached=%b in_ready=%b mem7=%h expected 1/1/0a", ok, in_ready, dut.mem[7]);
    end else
      $display("ok   start/ld_en ignored while busy");
    in_data = 8'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_q.push_back('{8'd7, 8'd6});
    wait_halt(50, n);
    checks++;
    if (n < 0 || pc !== 8'd3) begin
      errors++;
      $display("FAIL rerun halt: edge=%0d pc=%0d expected halt at pc=3", n, pc);
    end else
      $display("ok   rerun halted pc=3");
    drain_mem_q("rerun");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_taken();
    test_signed_wrap();
    test_input();
    test_output();
    test_reset_ctrl();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/subleq_mc_core.md
Name: subleq_mc_core

Overview:
- Parametrised multi-cycle SUBLEQ processor core with a unified instruction/data memory.
- Adds features the fixed 8-bit single-config core lacks:
  - program load port
  - start/halt control
  - valid/ready handshaked memory-mapped I/O
  - self-loop halt detection
- Instantiated by top-level SUBLEQ wrappers in place of the fixed core.

Parameters:
- AW, 8, address width; memory depth is 2**AW words.
- DW, 8, data word width, two's complement, DW >= AW.
- IO_ADDR, 2**AW-1, address decoded as the I/O port instead of memory.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin execution at PC=0 (sampled in IDLE or HALT)
- ld_en  input  1  write ld_data to mem[ld_addr] (IDLE or HALT only)
- ld_addr  input  AW  load address
- ld_data  input  DW  load data
- in_data  input  DW  input operand
- in_valid  input  1  in_data valid
- in_ready  output  1  core accepting input
- out_data  output  DW  output value
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepting output
- busy  output  1  state not IDLE/HALT
- halted  output  1  state == HALT
- pc  output  AW  current instruction address

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pc=0, ra/rb/rc/opa/opb=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0, halted=0.
  - Memory contents are not reset.
- Addresses: only the low AW bits of fetched words are used. pc+1, pc+2 and pc+3 wrap modulo 2**AW.
- Load: when ld_en is high in IDLE/HALT, mem[ld_addr]<=ld_data on the edge. Ignored while busy.
- States: IDLE, FA, FB, FC, OA, IN_WAIT, OB, EX, OUT_WAIT, HALT. Each state takes one cycle unless noted.
  - IDLE/HALT: start=1 -> pc<=0, go to FA. If ld_en and start are high together, the load is performed and execution begins (load visible to the first fetch). start while busy is ignored.
  - FA: ra<=mem[pc]. -> FB.
  - FB: rb<=mem[pc+1]. -> FC.
  - FC: rc<=mem[pc+2]. -> OA.
  - OA: if ra==IO_ADDR -> IN_WAIT; else opa<=mem[ra] -> OB.
  - IN_WAIT: in_ready=1 (combinational on state). When in_valid&&in_ready, opa<=in_data -> OB. Otherwise stall indefinitely.
  - OB: if rb==IO_ADDR, then out_data<=opa, out_valid<=1 -> OUT_WAIT. Else opb<=mem[rb] -> EX.
  - OUT_WAIT: out_valid and out_data held stable until out_valid&&out_ready. On that edge out_valid<=0, pc<=pc+3, -> FA. No memory write; branch never taken.
  - EX: r=opb-opa (DW-bit wrap, overflow ignored); mem[rb]<=r. Taken iff r sign bit set or r==0.
    - Taken with rc==pc: halt; pc unchanged, -> HALT.
    - Taken otherwise: pc<=rc, -> FA.
    - Not taken: pc<=pc+3, -> FA.
- Latency: 6 cycles per memory instruction; I/O instructions stretch by the handshake wait.
- Self-modifying code is legal: the EX write is visible to the next FA.
- rst_n asserted mid-instruction aborts immediately: no pending write, any handshake is dropped, out_valid returns to 0.

Test Plan:
- Basic run:
  - Stimulus: load mem[0..2]={6,7,3}, mem[3..5]={8,8,3}, mem[6]=5, mem[7]=7, mem[8]=0; pulse start.
  - Response: mem[7]==2; halted rises on the 12th edge after the start edge with pc==3; busy low thereafter.
- Taken branch:
  - Stimulus: mem[0..2]={6,7,9}, mem[6]=7, mem[7]=7, halt loop {8,8,9} at 9.
  - Response: mem[7]==0, pc jumps 0->9, halted with pc==9.
- Signed wrap:
  - Stimulus: DW=8, opb=0x80 (-128), opa=1.
  - Response: r=0x7F, stored, not taken, pc+=3.
- Input:
  - Stimulus: instr {255,7,3} with mem[7]=10; hold in_valid low 5 cycles, then in_data=4, in_valid=1.
  - Response: in_ready high throughout IN_WAIT; mem[7]==6 after EX.
- Output backpressure:
  - Stimulus: instr {6,255,3} with mem[6]=0x2A; out_ready low 4 cycles.
  - Response: out_valid=1, out_data=0x2A stable all 4 cycles; pc=3 after the handshake; no memory changed.
- Reset/control:
  - Stimulus: assert rst_n low during IN_WAIT.
  - Response: state IDLE, in_ready=0, pc=0, memory intact. start or ld_en pulsed while busy has no effect.
